// File: rtl/shift_reg_univ_pkg.sv
// Shared mode codes, sequencer states and helpers
// for the universal shift register.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SRL  = 3'b001;
  localparam logic [2:0] MODE_SLL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_SRA  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Modes that move bits and eject one through sout.
  function automatic logic is_shift_mode(
    input logic [2:0] m
  );
    return (m == MODE_SRL) ||
           (m == MODE_SLL) ||
           (m == MODE_ROR) ||
           (m == MODE_ROL) ||
           (m == MODE_SRA);
  endfunction

endpackage

// File: rtl/shift_reg_univ_step.sv
// One combinational step of the shift register,
// shared by single-step and sequenced operation.
module shift_step_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             Rin,
  input  logic             Lin,
  output logic [WIDTH-1:0] nq,
  output logic             ej,
  output logic             sv
);

  // Decode the mode into next value and ejected bit.
  always_comb begin
    nq = q;
    ej = 1'b0;
    sv = 1'b0;
    unique case (mode)
      MODE_HOLD: begin
        nq = q;
      end
      MODE_SRL: begin
        nq = {Rin, q[WIDTH-1:1]};
        ej = q[0];
        sv = 1'b1;
      end
      MODE_SLL: begin
        nq = {q[WIDTH-2:0], Lin};
        ej = q[WIDTH-1];
        sv = 1'b1;
      end
      MODE_LOAD: begin
        nq = data;
      end
      MODE_ROR: begin
        nq = {q[0], q[WIDTH-1:1]};
        ej = q[0];
        sv = 1'b1;
      end
      MODE_ROL: begin
        nq = {q[WIDTH-2:0], q[WIDTH-1]};
        ej = q[WIDTH-1];
        sv = 1'b1;
      end
      MODE_SRA: begin
        nq = {q[WIDTH-1], q[WIDTH-1:1]};
        ej = q[0];
        sv = 1'b1;
      end
      MODE_CLR: begin
        nq = '0;
      end
      default: begin
        nq = q;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with a multi-step
// sequencer and busy/done handshake.
module shift_reg_univ
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] data,
  input  logic             Rin,
  input  logic             Lin,
  output logic [WIDTH-1:0] Qout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_ej;
  logic             step_sv;

  // While sequencing, the latched mode drives the step.
  assign step_mode = (state_q == ST_BUSY) ? mode_q : mode;

  shift_step_unit #(
    .WIDTH(WIDTH)
  ) u_step (
    .q   (q_q),
    .mode(step_mode),
    .data(data),
    .Rin (Rin),
    .Lin (Lin),
    .nq  (step_q),
    .ej  (step_ej),
    .sv  (step_sv)
  );

  // Next-state, register value, sout and done pulse.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          cnt_d  = amt;
          if (amt == '0) begin
            done_d = 1'b1;
          end else if (!is_shift_mode(mode)) begin
            q_d    = step_q;
            done_d = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end else if (en) begin
          q_d = step_q;
          if (step_sv) begin
            sout_d = step_ej;
          end
        end
      end
      ST_BUSY: begin
        q_d   = step_q;
        cnt_d = cnt_q - AMT_W'(1);
        if (step_sv) begin
          sout_d = step_ej;
        end
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign Qout = q_q;
  assign sout = sout_q;
  assign busy = (state_q == ST_BUSY);
  assign done = done_q;

endmodule

// File: doc/shift_reg_univ.md
Name: shift_reg_univ

Overview:
- Parametrised universal shift register and the successor to the team's 4-bit shift/load register.
- Adds width parameterisation, rotate and arithmetic modes, and serial-out taps.
- Adds a multi-step sequencer: one start pulse performs N shift steps, one step per clock, with busy/done handshake.
- Used as a datapath serialiser/deserialiser and as a barrel-shift substitute where area matters more than latency.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- AMT_W, $clog2(WIDTH+1), width of the step-count input; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- en  in  1  single-step enable (ignored while busy)
- start  in  1  request a multi-step operation (pulse)
- mode  in  3  operation select
- amt  in  AMT_W  number of steps for start
- data  in  WIDTH  parallel load value
- Rin  in  1  serial in for shift-right (enters MSB)
- Lin  in  1  serial in for shift-left (enters LSB)
- Qout  out  WIDTH  register contents
- sout  out  1  bit ejected by the most recent shift (registered)
- busy  out  1  multi-step sequence in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: clr low, asynchronous → Qout=0, sout=0, busy=0, done=0, state IDLE, step counter=0.
- Mode encoding:
  - 000 hold
  - 001 SRL: Q = {Rin, Q[W-1:1]}, sout = Q[0]
  - 010 SLL: Q = {Q[W-2:0], Lin}, sout = Q[W-1]
  - 011 load: Q = data
  - 100 ROR: sout = Q[0]
  - 101 ROL: sout = Q[W-1]
  - 110 SRA: MSB replicated, sout = Q[0]
  - 111 sync clear: Q = 0
- sout updates only on shift/rotate steps; otherwise it holds.
- IDLE:
  - start=1 → accept. Latch mode and amt; Q unchanged this edge; done cleared.
    - amt=0 → stay IDLE; done=1 next cycle.
    - Non-shift mode (000/011/111) with start → executed once at the accept edge; done=1 next cycle; busy never asserts.
    - Shift/rotate mode with amt≥1 → go to BUSY; counter=amt.
  - Else if en=1 → apply mode once this edge (one-cycle latency).
  - start has priority over en.
- BUSY:
  - busy=1.
  - Each edge applies one step of the latched mode and decrements the counter.
  - Rin/Lin are sampled live at each step, so serial shift-in is supported.
  - mode, amt, data, en and start are ignored; start during BUSY is dropped, not queued.
  - Counter reaching 0 on a step → IDLE, busy=0, done=1 for exactly the following cycle, and final Qout is visible in that same cycle.
- Latency: start with amt=N (shift mode) → final Q after N+1 rising edges from the accept edge inclusive. busy is high for N cycles.
- amt > WIDTH is legal: shifts saturate naturally (SRL/SLL fill fully with serial input), rotates wrap modulo WIDTH.
- Back-to-back: start asserted in the done cycle is accepted; done and the new accept coexist, and done drops next cycle.
- Reset mid-BUSY aborts immediately; no done pulse.

Decomposition:
- Package shift_pkg:
  - mode localparams MODE_HOLD, MODE_SRL, MODE_SLL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_SRA, MODE_CLR
  - state encoding ST_IDLE/ST_BUSY
  - function is_shift_mode()
- Sub-module shift_step_unit (combinational, WIDTH param):
  - inputs: q, mode, data, Rin, Lin
  - outputs: next q, ejected bit, shift-valid flag
  - Instanced once, shared by the single-step and sequenced paths.

Test Plan:
- Reset/load: clr low mid-operation → Qout=0x00, busy=0, done=0 immediately; release, en=1, mode=011, data=0xA5 → Qout=0xA5 one edge later.
- Single-step shifts from 0xA5: SRL Rin=1 → 0xD2, sout=1; SLL Lin=0 from 0xA5 → 0x4A, sout=1; SRA from 0x85 → 0xC2; ROR 0x81 → 0xC0.
- Sequenced rotate: Q=0x81, start, mode=101, amt=3 → busy high 3 cycles; Q=0x03→0x06→0x0C; done pulse one cycle with Qout=0x0C.
- Serial deserialise: Q=0x00, start SLL amt=8, Lin stream 1,0,1,1,0,0,1,0 → Qout=0xB2 at done.
- Edge cases:
  - amt=0 → done next cycle, busy never high, Q unchanged.
  - start during BUSY → ignored, done count stays 1.
  - start in done cycle → accepted.
- Abort: clr pulsed low during BUSY at step 2 of 5 → Q=0, no done; next start runs normally.
